// File: rtl/dtc_vote_accum.sv
// dtc_vote_accum: windowed per-bit majority vote over classifier vectors.
// Define DTC_VOTE_FLUSH_EN to add a flush input that closes a window early.
module dtc_vote_accum #(
  parameter int WINDOW = 8,
  parameter int CNT_W = $clog2(WINDOW + 1)
) (
  input  logic       clk,
  input  logic       rst,
`ifdef DTC_VOTE_FLUSH_EN
  input  logic       flush,
`endif
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic [7:0] out_n
);
  typedef enum logic {ACCUM, HOLD} state_t;
  state_t state, state_nxt;
  logic [CNT_W-1:0] cnt [8];
  logic [CNT_W-1:0] cnt_nxt [8];
  logic [CNT_W-1:0] n, n_nxt;
  logic [7:0] maj;
  logic acc, close, flush_close;
  // Counts include this cycle's accepted sample so the final vote sees n_final.
  always_comb begin
    acc = in_valid && in_ready;
    n_nxt = n + CNT_W'(acc);
    maj = '0;
    for (int i = 0; i < 8; i++) begin
      cnt_nxt[i] = cnt[i] + CNT_W'(acc && in_data[i]);
      maj[i] = {cnt_nxt[i], 1'b0} > {1'b0, n_nxt};
    end
  end
`ifdef DTC_VOTE_FLUSH_EN
  assign flush_close = flush && n_nxt != '0;
`else
  assign flush_close = 1'b0;
`endif
  assign close = state == ACCUM && ((acc && n_nxt == CNT_W'(WINDOW)) || flush_close);
  always_ff @(posedge clk)
    state <= rst ? ACCUM : state_nxt;
  always_comb
    state_nxt = state == ACCUM ? (close ? HOLD : ACCUM) : (out_ready ? ACCUM : HOLD);
  always_comb begin
    in_ready = !rst && state == ACCUM;
    out_valid = state == HOLD;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '{default: '0};
      n <= '0;
      out_data <= '0;
      out_n <= '0;
    end else begin
      if (state == ACCUM) begin
        cnt <= cnt_nxt;
        n <= n_nxt;
      end else if (out_ready) begin
        cnt <= '{default: '0};
        n <= '0;
      end
      if (close) begin
        out_data <= maj;
        out_n <= 8'(n_nxt);
      end
    end
  end
endmodule

// File: tb/tb_dtc_vote_accum.sv
// tb_dtc_vote_accum: randomized and directed checks of two vote accumulators
// (WINDOW=4 and WINDOW=1) against a sample-list majority model.
module tb_dtc_vote_accum;
  logic clk = 0;
  logic rst = 1;
  logic iv [2] = '{0, 0};
  logic ir [2];
  logic [7:0] id [2] = '{8'h00, 8'h00};
  logic ov [2];
  logic ordy [2] = '{1, 1};
  logic [7:0] od [2];
  logic [7:0] on [2];
  logic fl [2] = '{0, 0};
  int tests = 0, errs = 0;
  int w [2] = '{4, 1};
  logic [7:0] smp [2][4];
  int ns [2] = '{0, 0};
  logic hold [2] = '{0, 0};
  logic acc_m [2] = '{0, 0};
  logic [7:0] md [2] = '{8'h00, 8'h00};
  int mn [2] = '{0, 0};
  int cyc = 0;

  always #5 clk = ~clk;

  dtc_vote_accum #(.WINDOW(4)) u4 (
    .clk(clk), .rst(rst),
`ifdef DTC_VOTE_FLUSH_EN
    .flush(fl[0]),
`endif
    .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]), .out_n(on[0]));

  dtc_vote_accum #(.WINDOW(1)) u1 (
    .clk(clk), .rst(rst),
`ifdef DTC_VOTE_FLUSH_EN
    .flush(fl[1]),
`endif
    .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]), .out_n(on[1]));

  task automatic chk(input string tag, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, a, e);
    end
  endtask

  function automatic logic [7:0] maj(input int k);
    logic [7:0] r = '0;
    for (int b = 0; b < 8; b++) begin
      int c = 0;
      for (int j = 0; j < ns[k]; j++) c += int'(smp[k][j][b]);
      r[b] = 2 * c > ns[k];
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      acc_m[k] = 0;
      if (rst) begin
        hold[k] = 0; ns[k] = 0; md[k] = '0; mn[k] = 0;
      end else if (hold[k]) begin
        if (ordy[k]) begin hold[k] = 0; ns[k] = 0; end
      end else begin
        if (iv[k]) begin smp[k][ns[k]] = id[k]; ns[k]++; acc_m[k] = 1; end
        if (ns[k] == w[k] || (fl[k] && ns[k] > 0)) begin
          md[k] = maj(k); mn[k] = ns[k]; hold[k] = 1;
        end
      end
    end
    cyc++;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("u%0d_in_ready", k), 32'(ir[k]), 32'(!rst && !hold[k]));
      chk($sformatf("u%0d_out_valid", k), 32'(ov[k]), 32'(hold[k]));
      chk($sformatf("u%0d_out_data", k), 32'(od[k]), 32'(md[k]));
      chk($sformatf("u%0d_out_n", k), 32'(on[k]), mn[k]);
    end
  endtask

  task automatic feed(input int k, input logic [7:0] d, input int gap);
    int t = 0;
    iv[k] = 1; id[k] = d;
    do begin tick(); t++; end while (!acc_m[k] && t < 50);
    if (!acc_m[k]) chk($sformatf("u%0d_accept_timeout", k), 32'(t), 32'(0));
    iv[k] = 0;
    repeat (gap) tick();
  endtask

  initial begin
    logic [7:0] pat [4] = '{8'hFF, 8'h0F, 8'h03, 8'h01};
    int c0;
    @(negedge clk);
    tick(); tick();
    rst = 0;
    tick();
    for (int i = 0; i < 4; i++) feed(0, pat[i], 0);
    chk("basic_data", 32'(od[0]), 32'h03);
    chk("basic_n", 32'(on[0]), 32'd4);
    chk("basic_valid", 32'(ov[0]), 32'd1);
    tick();
    chk("basic_valid_1cyc", 32'(ov[0]), 32'd0);
    ordy[0] = 0;
    for (int i = 0; i < 4; i++) feed(0, pat[i], 0);
    iv[0] = 1; id[0] = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", 32'(ov[0]), 32'd1);
      chk("bp_data", 32'(od[0]), 32'h03);
      chk("bp_ready", 32'(ir[0]), 32'd0);
    end
    iv[0] = 0; ordy[0] = 1;
    tick();
    for (int i = 0; i < 4; i++) feed(0, 8'h00, 0);
    chk("bp_clean_data", 32'(od[0]), 32'h00);
    chk("bp_clean_n", 32'(on[0]), 32'd4);
    tick();
    for (int i = 0; i < 4; i++) feed(0, pat[i], i == 3 ? 0 : int'($urandom_range(0, 3)));
    chk("gap_data", 32'(od[0]), 32'h03);
    chk("gap_n", 32'(on[0]), 32'd4);
    tick();
    feed(0, 8'hFF, 0); feed(0, 8'hFF, 0);
    rst = 1;
    tick();
    chk("rst_ready", 32'(ir[0]), 32'd0);
    chk("rst_valid", 32'(ov[0]), 32'd0);
    chk("rst_data", 32'(od[0]), 32'h00);
    chk("rst_n", 32'(on[0]), 32'd0);
    rst = 0;
    for (int i = 0; i < 4; i++) feed(0, 8'h00, 0);
    chk("rst_win_data", 32'(od[0]), 32'h00);
    chk("rst_win_n", 32'(on[0]), 32'd4);
    tick();
    feed(1, 8'hA5, 0);
    c0 = cyc;
    chk("w1_a_data", 32'(od[1]), 32'hA5);
    chk("w1_a_n", 32'(on[1]), 32'd1);
    feed(1, 8'h3C, 0);
    chk("w1_b_data", 32'(od[1]), 32'h3C);
    chk("w1_b_n", 32'(on[1]), 32'd1);
    chk("w1_spacing", 32'(cyc - c0), 32'd2);
    tick();
`ifdef DTC_VOTE_FLUSH_EN
    feed(0, 8'hF0, 0); feed(0, 8'hF0, 0);
    fl[0] = 1;
    feed(0, 8'h0F, 0);
    fl[0] = 0;
    chk("flush_data", 32'(od[0]), 32'hF0);
    chk("flush_n", 32'(on[0]), 32'd3);
    tick();
    fl[0] = 1;
    tick(); tick();
    chk("flush_empty", 32'(ov[0]), 32'd0);
    fl[0] = 0;
`endif
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < 2; k++) begin
        iv[k] = 1'($urandom_range(0, 3) != 0);
        id[k] = 8'($urandom);
        ordy[k] = 1'($urandom_range(0, 2) != 0);
      end
`ifdef DTC_VOTE_FLUSH_EN
      fl[0] = 1'($urandom_range(0, 7) == 0);
`endif
      rst = 1'($urandom_range(0, 99) == 0);
      tick();
    end
    rst = 0;
    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
endmodule
